// File: rtl/wb_trace_fifo.sv
// Write-back trace buffer: captures retired register write-backs {rd, data, seq}
// into a small FIFO drained over a valid/ready handshake; overflow is dropped and counted.
module wb_trace_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int SEQ_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_rd,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               out_rd,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic [SEQ_W-1:0]         drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [SEQ_W-1:0]  r_seq;
  logic [SEQ_W-1:0]  r_drop;

  logic [4:0]        r_mem_rd   [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [SEQ_W-1:0]  r_mem_seq  [DEPTH];

  logic w_qual;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  function automatic logic [SEQ_W-1:0] sat_inc(input logic [SEQ_W-1:0] v);
    return (&v) ? v : v + SEQ_W'(1);
  endfunction

  // A write to $zero is not a trace event at all; clear swallows everything.
  assign w_qual = wb_valid && (wb_rd != 5'd0) && !clear;
  assign w_full = (r_level == LVL_FULL);
  assign w_pop  = (r_level != '0) && out_ready && !clear;
  assign w_push = w_qual && (!w_full || w_pop);
  assign w_drop = w_qual && w_full && !w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_seq    <= '0;
      r_drop   <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_seq    <= '0;
      r_drop   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_qual) r_seq  <= r_seq + SEQ_W'(1);
      if (w_drop) r_drop <= sat_inc(r_drop);
    end
  end

  // Storage carries no reset; outputs are masked by the level instead.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wr_ptr]   <= wb_rd;
      r_mem_data[r_wr_ptr] <= wb_data;
      r_mem_seq[r_wr_ptr]  <= r_seq;
    end
  end

  assign out_valid  = (r_level != '0);
  assign out_rd     = out_valid ? r_mem_rd[r_rd_ptr]   : '0;
  assign out_data   = out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign out_seq    = out_valid ? r_mem_seq[r_rd_ptr]  : '0;
  assign level      = r_level;
  assign full       = w_full;
  assign empty      = (r_level == '0);
  assign drop_count = r_drop;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Randomized scoreboard bench for wb_trace_fifo: a queue-based reference model predicts
// stored records and status; a negedge monitor compares on every handshake.
module tb_wb_trace_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int SW    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int SMAX  = (1 << SW) - 1;

  logic          clk = 0;
  logic          reset = 1;
  logic          clear = 0;
  logic          wb_valid = 0;
  logic [4:0]    wb_rd = '0;
  logic [DW-1:0] wb_data = '0;
  logic          out_ready = 0;
  logic          out_valid;
  logic [4:0]    out_rd;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_seq;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic [SW-1:0] drop_count;

  wb_trace_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .SEQ_W(SW)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_data(out_data), .out_seq(out_seq),
    .level(level), .full(full), .empty(empty), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]    rd;
    logic [DW-1:0] data;
    logic [SW-1:0] seq;
  } rec_t;

  rec_t exp_q[$];
  int   m_seq = 0;
  int   m_drop = 0;
  int   chk_level = 0;
  int   chk_drop = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mon_en = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model to the next edge.
  task automatic cycle(input bit v, input logic [4:0] rd, input logic [DW-1:0] d,
                       input bit rdy, input bit clr);
    bit   pop;
    rec_t r;
    @(posedge clk);
    #1;
    chk_level = exp_q.size();
    chk_drop  = m_drop;
    wb_valid  = v;
    wb_rd     = rd;
    wb_data   = d;
    out_ready = rdy;
    clear     = clr;
    if (clr) begin
      exp_q.delete();
      m_seq  = 0;
      m_drop = 0;
    end else begin
      pop = (exp_q.size() > 0) && rdy;
      if (v && rd != 5'd0) begin
        if (exp_q.size() < DEPTH || pop) begin
          r.rd   = rd;
          r.data = d;
          r.seq  = m_seq[SW-1:0];
          exp_q.push_back(r);
        end else if (m_drop < SMAX) begin
          m_drop++;
        end
        m_seq = (m_seq + 1) % (1 << SW);
      end
    end
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 5'd0, '0, rdy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en && reset) begin
      check("level", level, chk_level);
      check("drop_count", drop_count, chk_drop);
      check("full", full, chk_level == DEPTH);
      check("empty", empty, chk_level == 0);
      check("out_valid", out_valid, chk_level != 0);
      if (!out_valid) begin
        check("idle_payload", {out_rd, out_data, out_seq}, 0);
      end else if (out_ready && !clear) begin
        check("model_has_record", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("out_rd", out_rd, exp_q[0].rd);
          check("out_data", out_data, exp_q[0].data);
          check("out_seq", out_seq, exp_q[0].seq);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int pcts[4];
    int pct;
    pcts[0] = 0; pcts[1] = 30; pcts[2] = 70; pcts[3] = 100;

    // Reset and first capture
    #1 reset = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_out_valid", out_valid, 0);
    reset  = 1;
    mon_en = 1;
    cycle(1'b1, 5'd8, 32'h5, 1'b0, 1'b0);
    idle(1'b0);
    check("first_rd", out_rd, 8);
    check("first_data", out_data, 5);
    check("first_seq", out_seq, 0);
    check("first_level", level, 1);

    // $zero filter
    cycle(1'b0, 5'd0, '0, 1'b0, 1'b1);
    repeat (3) cycle(1'b1, 5'd0, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 5'd9, 32'h99, 1'b0, 1'b0);
    idle(1'b0);
    check("zero_level", level, 1);
    check("zero_seq", out_seq, 0);
    check("zero_rd", out_rd, 9);

    // Overflow, then full with simultaneous push and pop, then drain
    cycle(1'b0, 5'd0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) cycle(1'b1, 5'(i), 32'(i * 16 + 3), 1'b0, 1'b0);
    idle(1'b0);
    check("ovf_full", full, 1);
    check("ovf_level", level, 8);
    check("ovf_drops", drop_count, 2);
    cycle(1'b1, 5'd11, 32'hB0B0, 1'b1, 1'b0);
    idle(1'b0);
    check("pp_level", level, 8);
    check("pp_drops", drop_count, 2);
    check("pp_head_seq", out_seq, 1);
    repeat (10) idle(1'b1);

    // Clear priority
    cycle(1'b0, 5'd0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 11; i++) cycle(1'b1, 5'(i + 3), $urandom, 1'b0, 1'b0);
    repeat (4) idle(1'b1);
    idle(1'b0);
    check("pre_clr_level", level, 4);
    check("pre_clr_drops", drop_count, 3);
    cycle(1'b1, 5'd5, 32'hDEAD, 1'b1, 1'b1);
    idle(1'b0);
    check("clr_level", level, 0);
    check("clr_empty", empty, 1);
    check("clr_drops", drop_count, 0);
    cycle(1'b1, 5'd6, 32'hBEEF, 1'b0, 1'b0);
    idle(1'b0);
    check("clr_next_seq", out_seq, 0);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 4; i++) cycle(1'b1, 5'(i + 20), $urandom, 1'b0, 1'b0);
    idle(1'b0);
    check("pre_rst_level", level, 5);
    #1 reset = 0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_level", level, 0);
    check("arst_empty", empty, 1);
    check("arst_payload", {out_rd, out_data, out_seq}, 0);
    exp_q.delete();
    m_seq = 0; m_drop = 0; chk_level = 0; chk_drop = 0;
    @(posedge clk);
    #1 reset = 1;

    // Randomized traffic with varying consumer rates, occasional clear
    pct = 50;
    for (int c = 0; c < 1200; c++) begin
      logic [4:0] rd;
      if (c % 50 == 0) pct = pcts[$urandom % 4];
      rd = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
      cycle(($urandom % 10) < 7, rd, $urandom, ($urandom % 100) < pct,
            ($urandom % 150) == 0);
    end

    // Sustained overflow to reach drop-counter saturation
    for (int c = 0; c < 40; c++) cycle(1'b1, 5'($urandom % 31 + 1), $urandom, 1'b0, 1'b0);
    idle(1'b0);
    check("sat_drops", drop_count, SMAX);

    repeat (12) idle(1'b1);
    idle(1'b0);
    check("final_level", level, exp_q.size());
    check("final_empty", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
